// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one main-memory port between three requesters: the I-cache fill FSM,
// the D-cache fill FSM and the D-cache write-through (store) path.
// Fixed priority, decided only in IDLE: store > D-fill > I-fill.
//
// A store owns memory for exactly one cycle.
// A fill owns memory until FILL_WORDS read-valid beats have returned.
// At least one IDLE cycle separates consecutive owners.
//
// Request/done handshake (all three requesters):
//   - A requester raises x_req and holds it, with a stable address/data,
//     until it sees its done pulse (wr_done / ic_fill_done / dc_fill_done).
//   - A done pulse is high for exactly one cycle, in the cycle of the final
//     beat.
//   - A fill cannot be revoked. If x_req drops mid-fill, the grant still
//     holds until all FILL_WORDS valids arrive, because those reads are
//     already in flight.
//
// Ports
//   i_clk, i_rst_n            clock; asynchronous active-low reset
//   i_ic_req / i_ic_addr      I-fill request and word address
//   i_dc_req / i_dc_addr      D-fill request and word address
//   i_wr_req / i_wr_addr /
//   i_wr_data                 store request, address and data
//   i_memory_data_valid       read-data valid beat from memory
//   o_mem_en / o_mem_wr /
//   o_mem_addr / o_mem_wdata  memory command (zero when not driven)
//   o_ic_grant / o_dc_grant   registered fill-owner indication
//   o_ic_data_valid /
//   o_dc_data_valid           memory valid routed to the fill owner
//   o_ic_fill_done /
//   o_dc_fill_done / o_wr_done  one-cycle completion pulses
//   o_busy                    arbiter not in IDLE
//   o_dbg_state / o_dbg_rcnt  FSM state and return-beat counter (debug)
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int FILL_WORDS = 8
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_ic_req,
    input  logic [ADDR_W-1:0]             i_ic_addr,
    input  logic                          i_dc_req,
    input  logic [ADDR_W-1:0]             i_dc_addr,
    input  logic                          i_wr_req,
    input  logic [ADDR_W-1:0]             i_wr_addr,
    input  logic [DATA_W-1:0]             i_wr_data,
    input  logic                          i_memory_data_valid,
    output logic                          o_mem_en,
    output logic                          o_mem_wr,
    output logic [ADDR_W-1:0]             o_mem_addr,
    output logic [DATA_W-1:0]             o_mem_wdata,
    output logic                          o_ic_grant,
    output logic                          o_dc_grant,
    output logic                          o_ic_data_valid,
    output logic                          o_dc_data_valid,
    output logic                          o_ic_fill_done,
    output logic                          o_dc_fill_done,
    output logic                          o_wr_done,
    output logic                          o_busy,
    output logic [1:0]                    o_dbg_state,
    output logic [$clog2(FILL_WORDS)-1:0] o_dbg_rcnt
);

    localparam int CNT_W = $clog2(FILL_WORDS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FILL_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WRITE  = 2'd1,
        S_FILL_I = 2'd2,
        S_FILL_D = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_rcnt;
    logic             r_ic_grant;
    logic             r_dc_grant;
    logic             w_in_fill;
    logic             w_last_beat;

    assign w_in_fill   = (r_state == S_FILL_I) || (r_state == S_FILL_D);
    // Final beat of a fill: a valid arriving while FILL_WORDS-1 beats are
    // already counted.
    assign w_last_beat = w_in_fill && i_memory_data_valid && (r_rcnt == LAST_CNT);

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_wr_req) begin
                    w_next_state = S_WRITE;
                end else if (i_dc_req) begin
                    w_next_state = S_FILL_D;
                end else if (i_ic_req) begin
                    w_next_state = S_FILL_I;
                end
            end
            S_WRITE: begin
                w_next_state = S_IDLE;
            end
            S_FILL_I, S_FILL_D: begin
                // Requests are deliberately ignored here; only the final
                // beat ends a fill.
                if (w_last_beat) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Return-beat counter and registered grants
    // ---------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rcnt     <= '0;
            r_ic_grant <= 1'b0;
            r_dc_grant <= 1'b0;
        end else begin
            // Holding the counter at zero in IDLE means every fill starts
            // from zero. It also means stray valids in IDLE or WRITE are
            // never counted.
            if (r_state == S_IDLE) begin
                r_rcnt <= '0;
            end else if (w_in_fill && i_memory_data_valid) begin
                // Wraps back to zero on the final beat.
                r_rcnt <= r_rcnt + CNT_W'(1);
            end
            r_ic_grant <= (w_next_state == S_FILL_I);
            r_dc_grant <= (w_next_state == S_FILL_D);
        end
    end

    // ---------------------------------------------------------------------
    // Output logic
    // ---------------------------------------------------------------------
    always_comb begin
        o_mem_en        = 1'b0;
        o_mem_wr        = 1'b0;
        o_mem_addr      = '0;
        o_mem_wdata     = '0;
        o_ic_data_valid = 1'b0;
        o_dc_data_valid = 1'b0;
        o_ic_fill_done  = 1'b0;
        o_dc_fill_done  = 1'b0;
        o_wr_done       = 1'b0;
        case (r_state)
            S_WRITE: begin
                o_mem_en    = 1'b1;
                o_mem_wr    = 1'b1;
                o_mem_addr  = i_wr_addr;
                o_mem_wdata = i_wr_data;
                o_wr_done   = 1'b1;
            end
            S_FILL_I: begin
                o_mem_en        = 1'b1;
                o_mem_addr      = i_ic_addr;
                o_ic_data_valid = i_memory_data_valid;
                o_ic_fill_done  = w_last_beat;
            end
            S_FILL_D: begin
                o_mem_en        = 1'b1;
                o_mem_addr      = i_dc_addr;
                o_dc_data_valid = i_memory_data_valid;
                o_dc_fill_done  = w_last_beat;
            end
            default: begin
            end
        endcase
    end

    assign o_ic_grant  = r_ic_grant;
    assign o_dc_grant  = r_dc_grant;
    assign o_busy      = (r_state != S_IDLE);
    assign o_dbg_state = r_state;
    assign o_dbg_rcnt  = r_rcnt;

endmodule
